// File: rtl/fold_pkg.sv
// Shared definitions for the instruction-folding group detector: fold-class
// bit positions, group identifiers and the length of each fold group.
package fold_pkg;

   // Width of one per-entry fold-class field
   localparam int CLS_W = 6;

   // Fold-class bit positions inside a class field
   localparam int NF  = 0;
   localparam int LV  = 1;
   localparam int OP  = 2;
   localparam int BG2 = 3;
   localparam int BG1 = 4;
   localparam int MEM = 5;

   typedef logic [CLS_W-1:0] cls_t;

   // Single-bit masks for each class, handy for testing a class field
   localparam cls_t M_NF  = cls_t'(1) << NF;
   localparam cls_t M_LV  = cls_t'(1) << LV;
   localparam cls_t M_OP  = cls_t'(1) << OP;
   localparam cls_t M_BG2 = cls_t'(1) << BG2;
   localparam cls_t M_BG1 = cls_t'(1) << BG1;
   localparam cls_t M_MEM = cls_t'(1) << MEM;

   // Group identifiers; G_NONE means nothing was folded
   localparam int N_GRP = 9;
   localparam logic [3:0] G_NONE = 4'd0;
   localparam logic [3:0] G1     = 4'd1;
   localparam logic [3:0] G2     = 4'd2;
   localparam logic [3:0] G3     = 4'd3;
   localparam logic [3:0] G4     = 4'd4;
   localparam logic [3:0] G5     = 4'd5;
   localparam logic [3:0] G6     = 4'd6;
   localparam logic [3:0] G7     = 4'd7;
   localparam logic [3:0] G8     = 4'd8;
   localparam logic [3:0] G9     = 4'd9;

   // Bytecodes consumed by each group, indexed by group number (0 unused)
   localparam logic [2:0] GRP_LEN [N_GRP+1] =
      '{3'd0, 3'd4, 3'd3, 3'd3, 3'd3, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2};

   // True when a valid entry carries the class selected by mask
   function automatic logic has_cls(input cls_t c, input logic v, input cls_t mask);
      return v & (|(c & mask));
   endfunction

endpackage

// File: rtl/fold_group_match.sv
// Combinational fold-group matcher: picks the longest enabled group that
// starts at window entry 0, lowest group number on equal length.
module fold_group_match
   import fold_pkg::*;
#(
   parameter int         WIN      = 4,
   parameter int         MAX_FOLD = 4,
   parameter logic [8:0] GRP_EN   = 9'h1FF
) (
   input  logic [WIN*CLS_W-1:0] win_type_i,
   input  logic [WIN-1:0]       win_vld_i,
   input  logic                 foe_i,
   output logic [2:0]           len_o,
   output logic [3:0]           grp_o,
   output logic                 notvalid_o
);

   // Window padded to four entries; missing entries read as invalid
   logic [4*CLS_W-1:0] typ_pad;
   logic [3:0]         vld_pad;
   logic [3:0]         is_lv, is_op, is_bg2, is_bg1, is_mem;
   logic [9:1]         hit;
   logic [9:1]         cand;

   assign typ_pad = (4*CLS_W)'(win_type_i);
   assign vld_pad = 4'(win_vld_i);

   // Per-entry class decode, qualified by the entry valid bit
   always_comb begin
      is_lv  = '0;
      is_op  = '0;
      is_bg2 = '0;
      is_bg1 = '0;
      is_mem = '0;
      for (int i = 0; i < 4; i++) begin
         is_lv[i]  = has_cls(typ_pad[i*CLS_W +: CLS_W], vld_pad[i], M_LV);
         is_op[i]  = has_cls(typ_pad[i*CLS_W +: CLS_W], vld_pad[i], M_OP);
         is_bg2[i] = has_cls(typ_pad[i*CLS_W +: CLS_W], vld_pad[i], M_BG2);
         is_bg1[i] = has_cls(typ_pad[i*CLS_W +: CLS_W], vld_pad[i], M_BG1);
         is_mem[i] = has_cls(typ_pad[i*CLS_W +: CLS_W], vld_pad[i], M_MEM);
      end
   end

   // Raw pattern match of every group against the window
   always_comb begin
      hit[1] = is_lv[0] & is_lv[1]  & is_op[2]  & is_mem[3];
      hit[2] = is_lv[0] & is_lv[1]  & is_op[2];
      hit[3] = is_lv[0] & is_lv[1]  & is_bg2[2];
      hit[4] = is_lv[0] & is_op[1]  & is_mem[2];
      hit[5] = is_lv[0] & is_bg2[1];
      hit[6] = is_lv[0] & is_bg1[1];
      hit[7] = is_lv[0] & is_op[1];
      hit[8] = is_lv[0] & is_mem[1];
      hit[9] = is_op[0] & is_mem[1];
   end

   // Candidates: matched, enabled, and short enough for this configuration
   always_comb begin
      cand = '0;
      for (int g = 1; g <= N_GRP; g++) begin
         cand[g] = foe_i & GRP_EN[g-1] & hit[g]
                 & (int'(GRP_LEN[g]) <= MAX_FOLD)
                 & (int'(GRP_LEN[g]) <= WIN);
      end
   end

   // Longest candidate wins; scanning downward lets the lowest number win ties
   always_comb begin
      len_o      = 3'd0;
      grp_o      = G_NONE;
      notvalid_o = ~vld_pad[0];
      if (vld_pad[0]) begin
         len_o = 3'd1;
         for (int g = N_GRP; g >= 1; g--) begin
            if (cand[g] && (GRP_LEN[g] >= len_o)) begin
               len_o = GRP_LEN[g];
               grp_o = 4'(g);
            end
         end
      end
   end

endmodule

// File: rtl/fold_group_stage.sv
// Registered fold-group stage: one-entry valid/ready output register in
// front of decode/issue, plus saturating per-length fold statistics.
module fold_group_stage
   import fold_pkg::*;
#(
   parameter int         WIN      = 4,
   parameter int         MAX_FOLD = 4,
   parameter logic [8:0] GRP_EN   = 9'h1FF,
   parameter int         CNT_W    = 16
) (
   input  logic                 clk,
   input  logic                 reset_l,
   input  logic                 foe,
   input  logic [WIN*CLS_W-1:0] win_type,
   input  logic [WIN-1:0]       win_vld,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2:0]           out_len,
   output logic [3:0]           out_grp,
   output logic                 out_notvalid,
   input  logic                 cnt_clr,
   input  logic [1:0]           cnt_sel,
   output logic [CNT_W-1:0]     cnt_val
);

   logic             vld_q, vld_d;
   logic [2:0]       len_q, len_d;
   logic [3:0]       grp_q, grp_d;
   logic             nv_q, nv_d;
   logic [CNT_W-1:0] cnt_q [4];
   logic [CNT_W-1:0] cnt_d [4];

   logic [2:0]       m_len;
   logic [3:0]       m_grp;
   logic             m_nv;
   logic             cap;
   logic             fire;
   logic [1:0]       inc_idx;

   fold_group_match #(
      .WIN      (WIN),
      .MAX_FOLD (MAX_FOLD),
      .GRP_EN   (GRP_EN)
   ) u_match (
      .win_type_i (win_type),
      .win_vld_i  (win_vld),
      .foe_i      (foe),
      .len_o      (m_len),
      .grp_o      (m_grp),
      .notvalid_o (m_nv)
   );

   assign in_ready = ~vld_q | out_ready;
   assign cap      = in_valid & in_ready;
   assign fire     = vld_q & out_ready;

   // Output register next state: load on capture, drain on consume, else hold
   always_comb begin
      vld_d = vld_q;
      len_d = len_q;
      grp_d = grp_q;
      nv_d  = nv_q;
      if (cap) begin
         vld_d = 1'b1;
         len_d = m_len;
         grp_d = m_grp;
         nv_d  = m_nv;
      end else if (out_ready) begin
         vld_d = 1'b0;
      end
   end

   // Output register; reset discards any pending decision
   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         vld_q <= 1'b0;
         len_q <= 3'd0;
         grp_q <= G_NONE;
         nv_q  <= 1'b0;
      end else begin
         vld_q <= vld_d;
         len_q <= len_d;
         grp_q <= grp_d;
         nv_q  <= nv_d;
      end
   end

   assign out_valid    = vld_q;
   assign out_len      = len_q;
   assign out_grp      = grp_q;
   assign out_notvalid = nv_q;

   // Statistics next state: clear wins, otherwise saturating bump on consume
   always_comb begin
      inc_idx = 2'(len_q - 3'd1);
      for (int i = 0; i < 4; i++) begin
         cnt_d[i] = cnt_q[i];
      end
      if (cnt_clr) begin
         for (int i = 0; i < 4; i++) begin
            cnt_d[i] = '0;
         end
      end else if (fire && (len_q != 3'd0) && (cnt_q[inc_idx] != '1)) begin
         cnt_d[inc_idx] = cnt_q[inc_idx] + CNT_W'(1);
      end
   end

   // Statistics counter flops
   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         for (int i = 0; i < 4; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign cnt_val = cnt_q[cnt_sel];

endmodule

// File: tb/tb_fold_group_stage.sv
// Bench for fold_group_stage: three configurations driven from shared
// stimulus (default, MAX_FOLD=3 with 4-bit counters, group 1 disabled).
module tb_fold_group_stage;
   import fold_pkg::*;

   logic        clk = 1'b0;
   logic        reset_l;
   logic        foe;
   logic [23:0] win_type;
   logic [3:0]  win_vld;
   logic        in_valid;
   logic        out_ready;
   logic        cnt_clr;
   logic [1:0]  cnt_sel;

   logic        ov [3];
   logic        ir [3];
   logic        nvo [3];
   logic [2:0]  ol [3];
   logic [3:0]  og [3];
   logic [15:0] cva, cvc;
   logic [3:0]  cvb;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   fold_group_stage #(.WIN(4), .MAX_FOLD(4), .GRP_EN(9'h1FF), .CNT_W(16)) dut_a (
      .clk(clk), .reset_l(reset_l), .foe(foe), .win_type(win_type), .win_vld(win_vld),
      .in_valid(in_valid), .in_ready(ir[0]), .out_valid(ov[0]), .out_ready(out_ready),
      .out_len(ol[0]), .out_grp(og[0]), .out_notvalid(nvo[0]),
      .cnt_clr(cnt_clr), .cnt_sel(cnt_sel), .cnt_val(cva));

   fold_group_stage #(.WIN(4), .MAX_FOLD(3), .GRP_EN(9'h1FF), .CNT_W(4)) dut_b (
      .clk(clk), .reset_l(reset_l), .foe(foe), .win_type(win_type), .win_vld(win_vld),
      .in_valid(in_valid), .in_ready(ir[1]), .out_valid(ov[1]), .out_ready(out_ready),
      .out_len(ol[1]), .out_grp(og[1]), .out_notvalid(nvo[1]),
      .cnt_clr(cnt_clr), .cnt_sel(cnt_sel), .cnt_val(cvb));

   fold_group_stage #(.WIN(4), .MAX_FOLD(4), .GRP_EN(9'h1FE), .CNT_W(16)) dut_c (
      .clk(clk), .reset_l(reset_l), .foe(foe), .win_type(win_type), .win_vld(win_vld),
      .in_valid(in_valid), .in_ready(ir[2]), .out_valid(ov[2]), .out_ready(out_ready),
      .out_len(ol[2]), .out_grp(og[2]), .out_notvalid(nvo[2]),
      .cnt_clr(cnt_clr), .cnt_sel(cnt_sel), .cnt_val(cvc));

   // Reference configuration of each instance
   int         d_maxf [3] = '{4, 3, 4};
   logic [8:0] d_en   [3] = '{9'h1FF, 9'h1FF, 9'h1FE};
   int         d_cmax [3] = '{65535, 15, 65535};

   // Group patterns as class indices per entry, with their lengths
   int PAT  [9][4] = '{'{LV, LV, OP, MEM}, '{LV, LV, OP, 0}, '{LV, LV, BG2, 0},
                       '{LV, OP, MEM, 0},  '{LV, BG2, 0, 0}, '{LV, BG1, 0, 0},
                       '{LV, OP, 0, 0},    '{LV, MEM, 0, 0}, '{OP, MEM, 0, 0}};
   int GLEN [9]    = '{4, 3, 3, 3, 2, 2, 2, 2, 2};

   // Reference model state per instance
   bit m_vld [3];
   int m_len [3];
   int m_grp [3];
   bit m_nv  [3];
   int m_cnt [3][4];

   function automatic cls_t ent(input logic [23:0] t, input int e);
      return t[e*6 +: 6];
   endfunction

   // Decision from the group table: longest legal match, lowest number on ties
   task automatic ref_decide(input logic [23:0] t, input logic [3:0] v, input logic f,
                             input int maxf, input logic [8:0] en,
                             output int len, output int grp, output bit nv);
      int   best;
      bit   ok;
      cls_t c;
      nv  = !v[0];
      len = v[0] ? 1 : 0;
      grp = 0;
      best = 0;
      if (v[0] && f) begin
         for (int g = 0; g < 9; g++) begin
            if (en[g] && GLEN[g] <= maxf) begin
               ok = 1'b1;
               for (int e = 0; e < GLEN[g]; e++) begin
                  c = ent(t, e);
                  if (!v[e] || !c[PAT[g][e]]) ok = 1'b0;
               end
               if (ok && GLEN[g] > best) begin
                  best = GLEN[g];
                  grp  = g + 1;
               end
            end
         end
         if (best > 0) len = best;
      end
   endtask

   always @(posedge clk or negedge reset_l) begin
      int  l, g;
      bit  n;
      bit  fire;
      if (!reset_l) begin
         for (int d = 0; d < 3; d++) begin
            m_vld[d] = 0; m_len[d] = 0; m_grp[d] = 0; m_nv[d] = 0;
            for (int k = 0; k < 4; k++) m_cnt[d][k] = 0;
         end
      end else begin
         for (int d = 0; d < 3; d++) begin
            fire = m_vld[d] && out_ready;
            if (cnt_clr) begin
               for (int k = 0; k < 4; k++) m_cnt[d][k] = 0;
            end else if (fire && m_len[d] > 0 && m_cnt[d][m_len[d]-1] < d_cmax[d]) begin
               m_cnt[d][m_len[d]-1]++;
            end
            if (in_valid && (!m_vld[d] || out_ready)) begin
               ref_decide(win_type, win_vld, foe, d_maxf[d], d_en[d], l, g, n);
               m_vld[d] = 1; m_len[d] = l; m_grp[d] = g; m_nv[d] = n;
            end else if (out_ready) begin
               m_vld[d] = 0;
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d, want %0d", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] cval(input int d);
      case (d)
         0:       return 32'(cva);
         1:       return 32'(cvb);
         default: return 32'(cvc);
      endcase
   endfunction

   task automatic check_all();
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("out_valid[%0d]", d), 32'(ov[d]), 32'(m_vld[d]));
         chk($sformatf("in_ready[%0d]", d), 32'(ir[d]), 32'(!m_vld[d] || out_ready));
         chk($sformatf("out_len[%0d]", d), 32'(ol[d]), 32'(m_len[d]));
         chk($sformatf("out_grp[%0d]", d), 32'(og[d]), 32'(m_grp[d]));
         chk($sformatf("out_notvalid[%0d]", d), 32'(nvo[d]), 32'(m_nv[d]));
         chk($sformatf("cnt_val[%0d] sel%0d", d, cnt_sel), cval(d), 32'(m_cnt[d][cnt_sel]));
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      check_all();
   endtask

   function automatic logic [23:0] W(input cls_t e0, input cls_t e1, input cls_t e2, input cls_t e3);
      return {e3, e2, e1, e0};
   endfunction

   function automatic cls_t pick();
      case ($urandom_range(0, 7))
         0, 1:    return M_LV;
         2:       return M_OP;
         3:       return M_MEM;
         4:       return M_BG1;
         5:       return M_BG2;
         6:       return M_NF;
         default: return cls_t'($urandom_range(0, 63));
      endcase
   endfunction

   typedef struct {
      logic [23:0] typ;
      logic [3:0]  vld;
      logic        f;
      logic [2:0]  la; logic [3:0] ga;
      logic [2:0]  lb; logic [3:0] gb;
      logic [2:0]  lc; logic [3:0] gc;
      logic        nv;
   } vec_t;

   vec_t tv [13];

   initial begin
      tv[0]  = '{W(M_LV, M_LV, M_OP, M_MEM), 4'hF, 1'b1, 3'd4, 4'd1, 3'd3, 4'd2, 3'd3, 4'd2, 1'b0};
      tv[1]  = '{W(M_LV, M_OP, M_MEM, M_NF), 4'h7, 1'b1, 3'd3, 4'd4, 3'd3, 4'd4, 3'd3, 4'd4, 1'b0};
      tv[2]  = '{W(M_LV, M_OP, M_MEM, M_NF), 4'h3, 1'b1, 3'd2, 4'd7, 3'd2, 4'd7, 3'd2, 4'd7, 1'b0};
      tv[3]  = '{W(M_LV, M_LV, M_OP, M_MEM), 4'hE, 1'b1, 3'd0, 4'd0, 3'd0, 4'd0, 3'd0, 4'd0, 1'b1};
      tv[4]  = '{W(M_LV, M_LV, M_OP, M_MEM), 4'hF, 1'b0, 3'd1, 4'd0, 3'd1, 4'd0, 3'd1, 4'd0, 1'b0};
      tv[5]  = '{W(M_LV, M_LV, M_BG2, M_NF), 4'hF, 1'b1, 3'd3, 4'd3, 3'd3, 4'd3, 3'd3, 4'd3, 1'b0};
      tv[6]  = '{W(M_OP, M_MEM, M_NF, M_NF), 4'hF, 1'b1, 3'd2, 4'd9, 3'd2, 4'd9, 3'd2, 4'd9, 1'b0};
      tv[7]  = '{W(M_LV, M_BG1, M_NF, M_NF), 4'hF, 1'b1, 3'd2, 4'd6, 3'd2, 4'd6, 3'd2, 4'd6, 1'b0};
      tv[8]  = '{W(M_LV | M_OP, M_MEM, M_NF, M_NF), 4'hF, 1'b1, 3'd2, 4'd8, 3'd2, 4'd8, 3'd2, 4'd8, 1'b0};
      tv[9]  = '{W(M_LV, M_LV, M_OP | M_MEM, M_MEM), 4'hF, 1'b1, 3'd4, 4'd1, 3'd3, 4'd2, 3'd3, 4'd2, 1'b0};
      tv[10] = '{W(M_NF, M_NF, M_NF, M_NF), 4'hF, 1'b1, 3'd1, 4'd0, 3'd1, 4'd0, 3'd1, 4'd0, 1'b0};
      tv[11] = '{W(M_LV, M_NF, M_NF, M_NF), 4'h1, 1'b1, 3'd1, 4'd0, 3'd1, 4'd0, 3'd1, 4'd0, 1'b0};
      tv[12] = '{W(M_LV, M_LV, M_OP, M_MEM), 4'h7, 1'b1, 3'd3, 4'd2, 3'd3, 4'd2, 3'd3, 4'd2, 1'b0};

      reset_l   = 1'b0;
      foe       = 1'b1;
      win_type  = '0;
      win_vld   = '0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      cnt_clr   = 1'b0;
      cnt_sel   = 2'd0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("rst out_valid[%0d]", d), 32'(ov[d]), 32'd0);
         chk($sformatf("rst in_ready[%0d]", d), 32'(ir[d]), 32'd1);
         chk($sformatf("rst out_len[%0d]", d), 32'(ol[d]), 32'd0);
         chk($sformatf("rst out_grp[%0d]", d), 32'(og[d]), 32'd0);
      end
      for (int s = 0; s < 4; s++) begin
         cnt_sel = 2'(s);
         #1;
         chk($sformatf("rst cnt sel%0d", s), 32'(cva), 32'd0);
      end
      reset_l = 1'b1;
      cnt_sel = 2'd3;

      // Table of windows, back-to-back with out_ready held high
      in_valid = 1'b1;
      for (int i = 0; i < 13; i++) begin
         win_type = tv[i].typ;
         win_vld  = tv[i].vld;
         foe      = tv[i].f;
         step();
         chk($sformatf("tv%0d len a", i), 32'(ol[0]), 32'(tv[i].la));
         chk($sformatf("tv%0d grp a", i), 32'(og[0]), 32'(tv[i].ga));
         chk($sformatf("tv%0d len b", i), 32'(ol[1]), 32'(tv[i].lb));
         chk($sformatf("tv%0d grp b", i), 32'(og[1]), 32'(tv[i].gb));
         chk($sformatf("tv%0d len c", i), 32'(ol[2]), 32'(tv[i].lc));
         chk($sformatf("tv%0d grp c", i), 32'(og[2]), 32'(tv[i].gc));
         chk($sformatf("tv%0d notvalid", i), 32'(nvo[0]), 32'(tv[i].nv));
         chk($sformatf("tv%0d out_valid", i), 32'(ov[0]), 32'd1);
      end

      // Stall: output holds, foe toggling does not disturb the held decision
      foe      = 1'b1;
      win_type = W(M_LV, M_LV, M_OP, M_MEM);
      win_vld  = 4'hF;
      step();
      out_ready = 1'b0;
      win_type  = W(M_OP, M_MEM, M_NF, M_NF);
      for (int k = 0; k < 3; k++) begin
         foe = k[0];
         step();
         chk($sformatf("stall%0d in_ready", k), 32'(ir[0]), 32'd0);
         chk($sformatf("stall%0d len", k), 32'(ol[0]), 32'd4);
         chk($sformatf("stall%0d grp", k), 32'(og[0]), 32'd1);
      end
      foe       = 1'b0;
      out_ready = 1'b1;
      step();
      chk("release out_valid", 32'(ov[0]), 32'd1);
      chk("release len", 32'(ol[0]), 32'd1);
      chk("release grp", 32'(og[0]), 32'd0);

      // Saturation of the len-2 counter in the 4-bit instance
      foe      = 1'b1;
      win_type = W(M_LV, M_OP, M_NF, M_NF);
      cnt_sel  = 2'd1;
      for (int k = 0; k < 18; k++) step();
      chk("sat len2 b", 32'(cvb), 32'hF);

      // Clear together with a handshake leaves the counters at zero
      cnt_clr = 1'b1;
      step();
      cnt_clr = 1'b0;
      chk("clr len2 a", 32'(cva), 32'd0);
      chk("clr len2 b", 32'(cvb), 32'd0);

      // Randomized traffic against the reference model
      for (int k = 0; k < 400; k++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         foe       = ($urandom_range(0, 7) != 0);
         cnt_clr   = ($urandom_range(0, 63) == 0);
         cnt_sel   = 2'($urandom_range(0, 3));
         win_type  = W(pick(), pick(), pick(), pick());
         win_vld   = ($urandom_range(0, 3) != 0) ? 4'hF : 4'($urandom_range(0, 15));
         step();
      end
      cnt_clr = 1'b0;

      // Reset pulse in the middle of a stall
      in_valid  = 1'b1;
      out_ready = 1'b0;
      win_type  = W(M_LV, M_LV, M_OP, M_MEM);
      win_vld   = 4'hF;
      foe       = 1'b1;
      step();
      step();
      #3;
      reset_l = 1'b0;
      #1;
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("midrst out_valid[%0d]", d), 32'(ov[d]), 32'd0);
         chk($sformatf("midrst in_ready[%0d]", d), 32'(ir[d]), 32'd1);
         chk($sformatf("midrst out_len[%0d]", d), 32'(ol[d]), 32'd0);
      end
      chk("midrst cnt a", 32'(cva), 32'd0);
      check_all();
      @(posedge clk);
      #1;
      reset_l   = 1'b1;
      out_ready = 1'b1;
      step();
      chk("postrst len", 32'(ol[0]), 32'd4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Absolute time bound so the run always ends
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/fold_group_stage.md
Name: fold_group_stage

Overview:
- Parametrised, registered successor to the combinational instruction-folding group detector in the IFU.
- Each cycle it accepts one decode window of up to WIN bytecodes with their fold-class codes and valid bits. It selects the longest enabled fold group, no longer than MAX_FOLD, that starts at entry 0.
- The decision is presented through a one-entry valid/ready pipeline register toward the decode/issue stage.
- Keeps saturating per-length fold statistics counters for performance tuning.

Parameters:
- WIN, 4, number of window entries presented; legal 2..4.
- MAX_FOLD, 4, largest group that may be folded; legal 1..WIN.
- GRP_EN, 9'h1FF, static enable mask; bit g-1 enables group g.
- CNT_W, 16, width of each statistics counter.

Ports:
- clk  in  1  core clock.
- reset_l  in  1  asynchronous active-low reset.
- foe  in  1  fold enable. When 0, no group is ever selected.
- win_type  in  WIN*6  fold class per entry. Entry i occupies bits [6i+5:6i]. Class bits: 0 NF, 1 LV, 2 OP, 3 BG2, 4 BG1, 5 MEM.
- win_vld  in  WIN  per-entry valid.
- in_valid  in  1  window presented.
- in_ready  out  1  stage can accept a window.
- out_valid  out  1  registered decision available.
- out_ready  in  1  consumer takes the decision.
- out_len  out  3  number of bytecodes consumed: 0..4.
- out_grp  out  4  matched group 1..9; 0 means no group.
- out_notvalid  out  1  entry 0 was invalid at capture.
- cnt_clr  in  1  synchronous clear of all counters.
- cnt_sel  in  2  counter select: 0 → len1, 1 → len2, 2 → len3, 3 → len4.
- cnt_val  out  CNT_W  selected counter value, combinational from the counter flops.

Behaviour:
- Group table. Entries are listed in order 0,1,2,3. An entry matches a class only if its valid bit is set and that class bit is set.
  - g1 LV LV OP MEM (len 4)
  - g2 LV LV OP (len 3)
  - g3 LV LV BG2 (len 3)
  - g4 LV OP MEM (len 3)
  - g5 LV BG2 (len 2)
  - g6 LV BG1 (len 2)
  - g7 LV OP (len 2)
  - g8 LV MEM (len 2)
  - g9 OP MEM (len 2)
- Candidate rule: a group is a candidate only if foe=1, its GRP_EN bit is set, its length ≤ MAX_FOLD, and its length ≤ WIN.
- Selection: the longest candidate wins. Among equal lengths, the lowest group number wins; this covers multi-hot class codes.
- Fallbacks:
  - No candidate and win_vld[0]=1 → out_len=1, out_grp=0.
  - win_vld[0]=0 → out_len=0, out_grp=0, out_notvalid=1.
- Handshake:
  - in_ready = !out_valid | out_ready.
  - Capture occurs on in_valid & in_ready. Latency is one clock from capture to out_valid.
  - While out_valid & !out_ready, out_len, out_grp and out_notvalid hold stable and in_valid is not consumed.
  - out_valid clears on out_ready unless a new capture occurs in the same cycle, in which case the output is replaced back-to-back with no bubble.
- Counters:
  - On out_valid & out_ready with out_len in 1..4, increment counter[out_len-1].
  - Counters saturate at all-ones and never wrap.
  - out_len=0 increments nothing.
  - cnt_clr has priority over a simultaneous increment; the result is 0.
- Reset: asserting reset_l low at any time, including mid-handshake, immediately forces:
  - out_valid=0, out_len=0, out_grp=0, out_notvalid=0;
  - all counters to 0.
  - in_ready therefore reads 1. The pending decision is discarded, not replayed.
- foe is sampled at capture only. Toggling foe while out_valid is held does not alter the registered decision.
- Invalid entries beyond the group length do not affect a shorter match. For example, LV OP with win_vld=4'b0011 selects g7.

Decomposition:
- Package fold_pkg holds:
  - class bit index constants (NF, LV, OP, BG2, BG1, MEM);
  - group ID constants G_NONE, G1..G9;
  - a constant array giving each group's length;
  - the 6-bit class field width.
- One combinational sub-module, fold_group_match. Inputs: window, valids, foe. Parameters: GRP_EN, MAX_FOLD, WIN. Outputs: len, grp, notvalid.
- The top level adds the pipeline register, the handshake and the counters.

Test Plan:
- Default parameters, foe=1, types LV,LV,OP,MEM, vld=4'hF, out_ready=1 → next cycle out_valid=1, out_len=4, out_grp=1; len4 counter=1.
- Same window with MAX_FOLD=3 → out_len=3, out_grp=2. Separately, GRP_EN bit0 cleared → out_len=3, out_grp=2.
- LV,OP,MEM,NF with vld=4'b0111 → out_len=3, out_grp=4. Same types with vld=4'b0011 → out_len=2, out_grp=7.
- win_vld[0]=0 → out_len=0, out_notvalid=1, all counters unchanged. foe=0 with LV,LV,OP,MEM → out_len=1, out_grp=0.
- Hold out_ready=0 for 3 cycles with in_valid=1 → in_ready=0 and the output stays stable. Then out_ready=1 → the next window is captured in the same cycle and appears the following cycle.
- Preload counter len2 to 16'hFFFF, then two len-2 handshakes → stays 16'hFFFF. Assert cnt_clr together with a handshake → reads 0. Pulse reset_l mid-stall → out_valid=0 immediately.
